// File: rtl/up5k_zx_pkg.sv
// up5k_zx_pkg: shared state encoding and SPI flash command constants for the ZX ROM loader.
`default_nettype none

package up5k_zx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAKE   = 3'd1,
        S_CMD    = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_FINISH = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam logic [7:0] FLASH_CMD_WAKE = 8'hAB;
    localparam int         WAKE_WAIT      = 64;

endpackage

`default_nettype wire

// File: rtl/up5k_zx_rom_loader_spi_byte_xfer.sv
// spi_byte_xfer: one-byte full-duplex SPI mode-0 shifter, SCK_DIV clk cycles per sck phase.
`default_nettype none

module spi_byte_xfer #(
    parameter int SCK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       active,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       tx_sh;
    logic [7:0]       rx_sh;
    logic             phase_end;

    assign phase_end = active && (div_cnt == DIV_W'(SCK_DIV - 1));
    // Asserted during the final high phase so a new byte can start on the same edge sck falls.
    assign byte_done = phase_end && sck && (bit_cnt == 3'd7);
    assign rx_byte   = rx_sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active  <= 1'b0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= 3'd0;
            tx_sh   <= 8'h00;
            rx_sh   <= 8'h00;
        end else if (go && (!active || byte_done)) begin
            active  <= 1'b1;
            sck     <= 1'b0;
            mosi    <= tx_byte[7];
            tx_sh   <= {tx_byte[6:0], 1'b0};
            div_cnt <= '0;
            bit_cnt <= 3'd0;
        end else if (active) begin
            if (phase_end) begin
                div_cnt <= '0;
                if (!sck) begin
                    sck   <= 1'b1;
                    rx_sh <= {rx_sh[6:0], miso};
                end else begin
                    sck <= 1'b0;
                    if (bit_cnt == 3'd7) begin
                        active <= 1'b0;
                        mosi   <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        mosi    <= tx_sh[7];
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                    end
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/up5k_zx_rom_loader.sv
// up5k_zx_rom_loader: copies the ZX ROM image from SPI flash (one READ burst) into the 16-bit ROM store.
// Optional macro ZX_FLASH_WAKE_EN sends a release-from-deep-power-down (0xAB) before the read.
`default_nettype none

import up5k_zx_pkg::*;

module up5k_zx_rom_loader #(
    parameter logic [23:0] FLASH_OFFSET = 24'h100000,
    parameter int          ROM_WORDS    = 8192,
    parameter int          SCK_DIV      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        flash_csn,
    output logic        flash_sck,
    output logic        flash_mosi,
    input  logic        flash_miso,
    output logic        rom_wen,
    output logic [13:0] rom_addr,
    output logic [15:0] rom_wdata,
    output logic        busy,
    output logic        done
);

    localparam logic [13:0] LAST_ADDR = 14'(ROM_WORDS - 1);
    localparam int          FIN_W     = $clog2(SCK_DIV + 1);
    localparam logic [31:0] CMD_FRAME = {FLASH_CMD_READ, FLASH_OFFSET};

    state_t           state;
    logic [2:0]       cmd_idx;
    logic             pair_hi;
    logic [7:0]       lo_byte;
    logic [FIN_W-1:0] fin_cnt;
    logic             go;
    logic             byte_done;
    logic             xfer_active;
    logic [7:0]       tx_byte;
    logic [7:0]       rx_byte;
`ifdef ZX_FLASH_WAKE_EN
    logic             wake_sent;
    logic [6:0]       wait_cnt;
`endif

    spi_byte_xfer #(
        .SCK_DIV (SCK_DIV)
    ) u_xfer (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .tx_byte   (tx_byte),
        .rx_byte   (rx_byte),
        .byte_done (byte_done),
        .active    (xfer_active),
        .sck       (flash_sck),
        .mosi      (flash_mosi),
        .miso      (flash_miso)
    );

    // cmd_idx counts bytes already handed to the shifter, so it selects the next byte to send.
    always_comb begin
        tx_byte = 8'h00;
        if (state == S_CMD) begin
            case (cmd_idx)
                3'd0:    tx_byte = CMD_FRAME[31:24];
                3'd1:    tx_byte = CMD_FRAME[23:16];
                3'd2:    tx_byte = CMD_FRAME[15:8];
                3'd3:    tx_byte = CMD_FRAME[7:0];
                default: tx_byte = 8'h00;
            endcase
        end
`ifdef ZX_FLASH_WAKE_EN
        if (state == S_WAKE) tx_byte = FLASH_CMD_WAKE;
`endif
    end

    // Bytes chain back-to-back except after the odd byte of a pair, where WRITE inserts one clk.
    always_comb begin
        go = 1'b0;
        case (state)
            S_CMD:   go = xfer_active ? byte_done : (cmd_idx == 3'd0);
            S_DATA:  go = byte_done && !pair_hi;
            S_WRITE: go = (rom_addr != LAST_ADDR);
`ifdef ZX_FLASH_WAKE_EN
            S_WAKE:  go = !xfer_active && !wake_sent;
`endif
            default: go = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            flash_csn <= 1'b1;
            rom_wen   <= 1'b0;
            rom_addr  <= 14'd0;
            rom_wdata <= 16'h0000;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_idx   <= 3'd0;
            pair_hi   <= 1'b0;
            lo_byte   <= 8'h00;
            fin_cnt   <= '0;
`ifdef ZX_FLASH_WAKE_EN
            wake_sent <= 1'b0;
            wait_cnt  <= 7'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !done) begin
                        busy      <= 1'b1;
                        rom_addr  <= 14'd0;
                        cmd_idx   <= 3'd0;
                        pair_hi   <= 1'b0;
                        flash_csn <= 1'b0;
`ifdef ZX_FLASH_WAKE_EN
                        wake_sent <= 1'b0;
                        state     <= S_WAKE;
`else
                        state     <= S_CMD;
`endif
                    end
                end
`ifdef ZX_FLASH_WAKE_EN
                S_WAKE: begin
                    if (go) wake_sent <= 1'b1;
                    if (byte_done) begin
                        flash_csn <= 1'b1;
                        wait_cnt  <= 7'd0;
                    end else if (flash_csn) begin
                        if (wait_cnt == 7'(WAKE_WAIT - 1)) begin
                            flash_csn <= 1'b0;
                            state     <= S_CMD;
                        end else begin
                            wait_cnt <= wait_cnt + 7'd1;
                        end
                    end
                end
`endif
                S_CMD: begin
                    if (go && cmd_idx != 3'd4) cmd_idx <= cmd_idx + 3'd1;
                    if (byte_done && cmd_idx == 3'd4) state <= S_DATA;
                end
                S_DATA: begin
                    if (byte_done) begin
                        pair_hi <= !pair_hi;
                        if (!pair_hi) begin
                            lo_byte <= rx_byte;
                        end else begin
                            rom_wdata <= {rx_byte, lo_byte};
                            rom_wen   <= 1'b1;
                            state     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    rom_wen <= 1'b0;
                    if (rom_addr == LAST_ADDR) begin
                        flash_csn <= 1'b1;
                        fin_cnt   <= '0;
                        state     <= S_FINISH;
                    end else begin
                        rom_addr <= rom_addr + 14'd1;
                        state    <= S_DATA;
                    end
                end
                S_FINISH: begin
                    if (fin_cnt == FIN_W'(SCK_DIV)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        fin_cnt <= fin_cnt + FIN_W'(1);
                    end
                end
                S_DONE:  state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_up5k_zx_rom_loader.sv
// tb_up5k_zx_rom_loader: scoreboard bench with a behavioural SPI flash model for up5k_zx_rom_loader.
`default_nettype none

module tb_up5k_zx_rom_loader;

    localparam int          N   = 160;
    localparam int          D   = 2;
    localparam logic [23:0] OFS = 24'h100000;
    localparam int          N4  = 4;
    localparam int          D4  = 1;
`ifdef ZX_FLASH_WAKE_EN
    localparam int WAKE_EXTRA_M = 1 + 16 * D + 64;
    localparam int WAKE_EXTRA_4 = 1 + 16 * D4 + 64;
    localparam int CSN_FALLS    = 2;
`else
    localparam int WAKE_EXTRA_M = 0;
    localparam int WAKE_EXTRA_4 = 0;
    localparam int CSN_FALLS    = 1;
`endif
    localparam int LAT_MAIN = (32 + 16 * N) * 2 * D + N + D + 2 + WAKE_EXTRA_M;
    localparam int LAT4     = (32 + 16 * N4) * 2 * D4 + N4 + D4 + 2 + WAKE_EXTRA_4;

    logic        clk, reset, start, start4;
    logic        flash_csn, flash_sck, flash_mosi, flash_miso;
    logic        rom_wen, busy, done;
    logic [13:0] rom_addr;
    logic [15:0] rom_wdata;
    logic        csn4, sck4, mosi4, wen4, busy4, done4;
    logic [13:0] addr4;
    logic [15:0] wdata4;

    up5k_zx_rom_loader #(.FLASH_OFFSET(OFS), .ROM_WORDS(N), .SCK_DIV(D)) dut (
        .clk(clk), .reset(reset), .start(start),
        .flash_csn(flash_csn), .flash_sck(flash_sck), .flash_mosi(flash_mosi), .flash_miso(flash_miso),
        .rom_wen(rom_wen), .rom_addr(rom_addr), .rom_wdata(rom_wdata), .busy(busy), .done(done)
    );

    up5k_zx_rom_loader #(.FLASH_OFFSET(OFS), .ROM_WORDS(N4), .SCK_DIV(D4)) dut4 (
        .clk(clk), .reset(reset), .start(start4),
        .flash_csn(csn4), .flash_sck(sck4), .flash_mosi(mosi4), .flash_miso(1'b0),
        .rom_wen(wen4), .rom_addr(addr4), .rom_wdata(wdata4), .busy(busy4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flash contents relative to OFS, and the expected write stream.
    logic [7:0] mem [0:2*N-1];
    typedef struct {
        logic [13:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t exp_q[$];
    int  wen_count  = 0;
    int  csn_falls  = 0;
    int  wake_seen  = 0;
    bit  armed      = 0;

    task automatic load_expect();
        wr_t w;
        exp_q.delete();
        for (int k = 0; k < N; k++) begin
            w.a = 14'(k);
            w.d = {mem[2*k+1], mem[2*k]};
            exp_q.push_back(w);
        end
    endtask

    always @(negedge clk) begin
        if (rom_wen === 1'b1) begin
            wen_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got addr %0d data %0h expected no write", rom_addr, rom_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(rom_addr), 64'(e.a));
                check("wr_data", 64'(rom_wdata), 64'(e.d));
            end
        end
    end

    // Behavioural SPI flash: 32-bit command frame, then READ data shifted out on sck falling edges.
    int          nbits = 0;
    logic [31:0] cmd_sr = 32'h0;
    time         wake_rise = 0;
    bit          wake_pending = 0;

    initial flash_miso = 1'b0;

    always @(negedge flash_csn) begin
        csn_falls++;
        nbits  = 0;
        cmd_sr = 32'h0;
        if (wake_pending) begin
            check("wake_gap_ge64", 64'(($time - wake_rise) >= 640), 64'd1);
            wake_pending = 0;
        end
    end

    always @(posedge flash_csn) begin
        if (armed && nbits == 8) begin
            check("wake_byte", 64'(cmd_sr[7:0]), 64'h00AB);
            wake_rise    = $time;
            wake_pending = 1;
            wake_seen++;
        end
    end

    always @(flash_csn) begin
        if (armed) begin
            #1;
            check("sck_low_at_csn_edge", 64'(flash_sck), 64'd0);
        end
    end

    always @(posedge flash_sck) begin
        if (flash_csn === 1'b0) begin
            if (nbits < 32) cmd_sr = {cmd_sr[30:0], flash_mosi};
            nbits++;
            if (nbits == 32) check("cmd_frame", 64'(cmd_sr), 64'h03100000);
        end
    end

    always @(negedge flash_sck) begin
        if (flash_csn === 1'b0 && nbits >= 32 && cmd_sr[31:24] == 8'h03) begin
            int         d, idx;
            logic [7:0] b;
            d   = nbits - 32;
            idx = int'(cmd_sr[23:0]) - int'(OFS) + d / 8;
            b   = (idx >= 0 && idx < 2 * N) ? mem[idx] : 8'h00;
            flash_miso = b[7 - (d % 8)];
        end
    end

    // Pulses start, then counts clk cycles until done; optionally re-pulses start mid-load.
    task automatic run_load(input int limit, input bit inject, output int cyc, output logic prev_busy);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc       = 0;
        prev_busy = busy;
        while (!done && cyc < limit) begin
            prev_busy = busy;
            @(negedge clk);
            cyc++;
            start = (inject && rom_wen && rom_addr == 14'd20) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
    endtask

    initial begin
        int   cyc, falls0;
        logic pb;
        reset  = 1'b1;
        start  = 1'b0;
        start4 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_csn",   64'(flash_csn),  64'd1);
        check("rst_sck",   64'(flash_sck),  64'd0);
        check("rst_mosi",  64'(flash_mosi), 64'd0);
        check("rst_wen",   64'(rom_wen),    64'd0);
        check("rst_addr",  64'(rom_addr),   64'd0);
        check("rst_wdata", 64'(rom_wdata),  64'd0);
        check("rst_busy",  64'(busy),       64'd0);
        check("rst_done",  64'(done),       64'd0);
        reset = 1'b0;
        armed = 1;

        // Exact start-to-done latency on the small instance.
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        cyc = 0;
        pb  = busy4;
        while (!done4 && cyc < LAT4 + 100) begin
            pb = busy4;
            @(negedge clk);
            cyc++;
        end
        check("lat4_cycles", 64'(cyc), 64'(LAT4));
        check("lat4_busy_before", 64'(pb), 64'd1);
        check("lat4_busy_fall", 64'(busy4), 64'd0);

        // Full image with byte[i] = i, plus an ignored start during DATA.
        for (int i = 0; i < 2 * N; i++) mem[i] = 8'(i);
        load_expect();
        wen_count = 0;
        falls0    = csn_falls;
        run_load(LAT_MAIN + 200, 1'b1, cyc, pb);
        check("full_latency", 64'(cyc), 64'(LAT_MAIN));
        check("full_busy_before", 64'(pb), 64'd1);
        check("full_busy_fall", 64'(busy), 64'd0);
        check("full_all_written", 64'(exp_q.size()), 64'd0);
        check("full_wen_count", 64'(wen_count), 64'(N));
        check("full_csn_falls", 64'(csn_falls - falls0), 64'(CSN_FALLS));

        // Start after done is ignored.
        falls0 = csn_falls;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (200) @(negedge clk);
        check("post_done_csn_falls", 64'(csn_falls - falls0), 64'd0);
        check("post_done_wen_count", 64'(wen_count), 64'(N));
        check("post_done_done", 64'(done), 64'd1);
        check("post_done_busy", 64'(busy), 64'd0);

        // Reset mid-load with random flash contents.
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check("rearm_done", 64'(done), 64'd0);
        for (int i = 0; i < 2 * N; i++) mem[i] = 8'($urandom);
        load_expect();
        wen_count = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (!(rom_wen && rom_addr == 14'd100) && cyc < LAT_MAIN) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_reached_word100", 64'(rom_wen && rom_addr == 14'd100), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("mid_csn",  64'(flash_csn), 64'd1);
        check("mid_sck",  64'(flash_sck), 64'd0);
        check("mid_wen",  64'(rom_wen),   64'd0);
        check("mid_busy", 64'(busy),      64'd0);
        check("mid_done", 64'(done),      64'd0);
        check("mid_addr", 64'(rom_addr),  64'd0);
        check("mid_wen_count", 64'(wen_count), 64'd101);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reload from word 0 after the interrupted load.
        load_expect();
        wen_count = 0;
        falls0    = csn_falls;
        run_load(LAT_MAIN + 200, 1'b0, cyc, pb);
        check("reload_latency", 64'(cyc), 64'(LAT_MAIN));
        check("reload_all_written", 64'(exp_q.size()), 64'd0);
        check("reload_wen_count", 64'(wen_count), 64'(N));
        check("reload_csn_falls", 64'(csn_falls - falls0), 64'(CSN_FALLS));
        check("reload_done", 64'(done), 64'd1);
`ifdef ZX_FLASH_WAKE_EN
        check("wake_sessions", 64'(wake_seen), 64'd3);
`endif

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
